wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter
//  Description : Round-robin arbiter that shares one writeback port between
//                several execution units. Grant is combinational; the
//                writeback bus is registered with one cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int MAX_IDS   = 8,
  localparam int IDW      = $clog2(MAX_IDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_UNITS-1:0]     unit_done,
  input  logic [NUM_UNITS*IDW-1:0] unit_id,
  input  logic [NUM_UNITS*32-1:0]  unit_rd,
  output logic [NUM_UNITS-1:0]     unit_ack,
  input  logic                     writeback_suppress,
  output logic                     wb_valid,
  output logic [IDW-1:0]           wb_id,
  output logic [31:0]              wb_data,
  output logic [15:0]              grant_count
);

  // After reset the pointer sits on the last unit so unit 0 is searched first.
  localparam logic [2:0] c_ptr_rst = 3'(NUM_UNITS - 1);
  localparam logic [3:0] c_num     = 4'(NUM_UNITS);

  logic [2:0]     r_last_grant;
  logic [7:0]     w_done8;
  logic [3:0]     w_cand;
  logic           w_any;
  logic [2:0]     w_gnt_idx;
  logic           w_block;
  logic [IDW-1:0] w_sel_id;
  logic [31:0]    w_sel_data;

  // Search units starting just after the last winner; first requester wins.
  always_comb begin
    w_done8                  = '0;
    w_done8[NUM_UNITS-1:0]   = unit_done;
    w_any                    = 1'b0;
    w_gnt_idx                = r_last_grant;
    w_cand                   = '0;
    w_block                  = rst | writeback_suppress;
    for (int k = 1; k <= NUM_UNITS; k++) begin
      // Pointer is always below NUM_UNITS, so one subtraction wraps the sum.
      w_cand = {1'b0, r_last_grant} + 4'(k);
      if (w_cand >= c_num) begin
        w_cand = w_cand - c_num;
      end
      if (!w_block && !w_any && w_done8[w_cand[2:0]]) begin
        w_any     = 1'b1;
        w_gnt_idx = w_cand[2:0];
      end
    end
  end

  // Decode the winning index into a one-hot acknowledge.
  always_comb begin
    unit_ack = '0;
    for (int j = 0; j < NUM_UNITS; j++) begin
      unit_ack[j] = w_any && (w_gnt_idx == 3'(j));
    end
  end

  // Select the granted unit's ID and data for the writeback register.
  always_comb begin
    w_sel_id   = '0;
    w_sel_data = '0;
    for (int j = 0; j < NUM_UNITS; j++) begin
      if (unit_ack[j]) begin
        w_sel_id   = unit_id[j*IDW +: IDW];
        w_sel_data = unit_rd[j*32 +: 32];
      end
    end
  end

  // Writeback register, priority pointer and saturating grant counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= c_ptr_rst;
      wb_valid     <= 1'b0;
      wb_id        <= '0;
      wb_data      <= '0;
      grant_count  <= '0;
    end else begin
      wb_valid <= w_any;
      if (w_any) begin
        r_last_grant <= w_gnt_idx;
        wb_id        <= w_sel_id;
        wb_data      <= w_sel_data;
        if (grant_count != 16'hFFFF) begin
          grant_count <= grant_count + 16'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire
